video_timing_gen: RTL

Parametrised raster timing generator; successor to the fixed 25 MHz vertical/horizontal draw counter. Produces h_sync, v_sync, draw_flag, active-pixel coordinates and line/frame strobes from runtime-programmable porch, sync and active lengths, with totals derived internally. Timing inputs are shadow-latched once per frame, so software may reprogram the mode without tearing. Sits between the mode/configuration registers and the pixel source / TMDS encoder of the HDMI_TX path.

---
 rtl/video_timing_gen.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Each line and each frame runs back porch, active, front porch, then sync. Field
// lengths are programmable at runtime and the totals are derived internally.
// The timing inputs are shadow-latched during reset and on the last pixel of every
// frame, so a mode change never tears the frame that is on screen.
// Optional feature macro: VTG_SYNC_POLARITY_EN adds the h_sync_pol/v_sync_pol inputs
// (1 = active-high sync, 0 = active-low sync).
module video_timing_gen #(
    parameter int CNT_W = 12
) (
    input  logic             clock_25,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] h_back_porch,
    input  logic [CNT_W-1:0] h_active_pixels,
    input  logic [CNT_W-1:0] h_front_porch,
    input  logic [CNT_W-1:0] h_sync_length,
    input  logic [CNT_W-1:0] v_back_porch,
    input  logic [CNT_W-1:0] v_active_pixels,
    input  logic [CNT_W-1:0] v_front_porch,
    input  logic [CNT_W-1:0] v_sync_length,
`ifdef VTG_SYNC_POLARITY_EN
    input  logic             h_sync_pol,
    input  logic             v_sync_pol,
`endif
    output logic             h_sync,
    output logic             v_sync,
    output logic             draw_flag,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    // Two extra bits so that the sum of four fields can never overflow.
    localparam int CW = CNT_W + 2;

    logic [CNT_W-1:0] hBp_q, hAct_q, hFp_q, hSl_q;
    logic [CNT_W-1:0] vBp_q, vAct_q, vFp_q, vSl_q;
    logic [CNT_W-1:0] hBp_d, hAct_d, hFp_d, hSl_d;
    logic [CNT_W-1:0] vBp_d, vAct_d, vFp_d, vSl_d;
    logic             hPol_q, vPol_q, hPol_d, vPol_d;

    logic [CW-1:0]    hCnt_q, vCnt_q, hCnt_d, vCnt_d;

    logic             hSyncOut_q, vSyncOut_q, draw_q, lineStart_q, frameStart_q;
    logic             hSyncOut_d, vSyncOut_d, draw_d, lineStart_d, frameStart_d;
    logic [CNT_W-1:0] pixelX_q, pixelY_q, pixelX_d, pixelY_d;

    logic [CW-1:0]    hActStart, hActEnd, hSyncStart, hTotal;
    logic [CW-1:0]    vActStart, vActEnd, vSyncStart, vTotal;
    logic             degenerate, hLast, vLast, frameEnd;
    logic             hActive, vActive, hSyncDec, vSyncDec;
    logic             hSyncLevel, vSyncLevel, hSyncIdle, vSyncIdle;
    logic             rstHSync, rstVSync;

    // Region boundaries and totals, all derived from the shadowed field lengths.
    assign hActStart  = CW'(hBp_q);
    assign hActEnd    = hActStart + CW'(hAct_q);
    assign hSyncStart = hActEnd + CW'(hFp_q);
    assign hTotal     = hSyncStart + CW'(hSl_q);
    assign vActStart  = CW'(vBp_q);
    assign vActEnd    = vActStart + CW'(vAct_q);
    assign vSyncStart = vActEnd + CW'(vFp_q);
    assign vTotal     = vSyncStart + CW'(vSl_q);

    assign degenerate = (hTotal == '0) || (vTotal == '0);
    assign hLast      = (hCnt_q == hTotal - CW'(1));
    assign vLast      = (vCnt_q == vTotal - CW'(1));
    assign frameEnd   = hLast && vLast;

    // Zero-length fields give empty ranges, so those regions never assert.
    assign hActive  = (hCnt_q >= hActStart) && (hCnt_q < hActEnd);
    assign vActive  = (vCnt_q >= vActStart) && (vCnt_q < vActEnd);
    assign hSyncDec = (hCnt_q >= hSyncStart) && (hCnt_q < hTotal);
    assign vSyncDec = (vCnt_q >= vSyncStart) && (vCnt_q < vTotal);

`ifdef VTG_SYNC_POLARITY_EN
    assign hSyncLevel = ~(hSyncDec ^ hPol_q);
    assign vSyncLevel = ~(vSyncDec ^ vPol_q);
    assign hSyncIdle  = ~hPol_q;
    assign vSyncIdle  = ~vPol_q;
    assign rstHSync   = ~h_sync_pol;
    assign rstVSync   = ~v_sync_pol;
    assign hPol_d     = (en && (degenerate || frameEnd)) ? h_sync_pol : hPol_q;
    assign vPol_d     = (en && (degenerate || frameEnd)) ? v_sync_pol : vPol_q;
`else
    assign hSyncLevel = hSyncDec;
    assign vSyncLevel = vSyncDec;
    assign hSyncIdle  = 1'b0;
    assign vSyncIdle  = 1'b0;
    assign rstHSync   = 1'b0;
    assign rstVSync   = 1'b0;
    assign hPol_d     = 1'b1;
    assign vPol_d     = 1'b1;
`endif

    // Shadow reload: on the last pixel of a frame, or every enabled cycle while degenerate.
    always_comb begin
        hBp_d  = hBp_q;
        hAct_d = hAct_q;
        hFp_d  = hFp_q;
        hSl_d  = hSl_q;
        vBp_d  = vBp_q;
        vAct_d = vAct_q;
        vFp_d  = vFp_q;
        vSl_d  = vSl_q;
        if (en && (degenerate || frameEnd)) begin
            hBp_d  = h_back_porch;
            hAct_d = h_active_pixels;
            hFp_d  = h_front_porch;
            hSl_d  = h_sync_length;
            vBp_d  = v_back_porch;
            vAct_d = v_active_pixels;
            vFp_d  = v_front_porch;
            vSl_d  = v_sync_length;
        end
    end

    // Counter advance and registered decode of the current counter position.
    always_comb begin
        hCnt_d       = hCnt_q;
        vCnt_d       = vCnt_q;
        hSyncOut_d   = hSyncOut_q;
        vSyncOut_d   = vSyncOut_q;
        draw_d       = draw_q;
        pixelX_d     = pixelX_q;
        pixelY_d     = pixelY_q;
        lineStart_d  = 1'b0;
        frameStart_d = 1'b0;
        if (en) begin
            if (degenerate) begin
                hCnt_d     = '0;
                vCnt_d     = '0;
                hSyncOut_d = hSyncIdle;
                vSyncOut_d = vSyncIdle;
                draw_d     = 1'b0;
                pixelX_d   = '0;
                pixelY_d   = '0;
            end else begin
                hSyncOut_d   = hSyncLevel;
                vSyncOut_d   = vSyncLevel;
                draw_d       = hActive && vActive;
                pixelX_d     = (hActive && vActive) ? CNT_W'(hCnt_q - hActStart) : '0;
                pixelY_d     = (hActive && vActive) ? CNT_W'(vCnt_q - vActStart) : '0;
                lineStart_d  = (hCnt_q == '0);
                frameStart_d = (hCnt_q == '0) && (vCnt_q == '0);
                if (hLast) begin
                    hCnt_d = '0;
                    vCnt_d = vLast ? '0 : vCnt_q + CW'(1);
                end else begin
                    hCnt_d = hCnt_q + CW'(1);
                end
            end
        end
    end

    // State register with synchronous reset; reset also captures the timing inputs.
    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            hBp_q        <= h_back_porch;
            hAct_q       <= h_active_pixels;
            hFp_q        <= h_front_porch;
            hSl_q        <= h_sync_length;
            vBp_q        <= v_back_porch;
            vAct_q       <= v_active_pixels;
            vFp_q        <= v_front_porch;
            vSl_q        <= v_sync_length;
`ifdef VTG_SYNC_POLARITY_EN
            hPol_q       <= h_sync_pol;
            vPol_q       <= v_sync_pol;
`else
            hPol_q       <= 1'b1;
            vPol_q       <= 1'b1;
`endif
            hSyncOut_q   <= rstHSync;
            vSyncOut_q   <= rstVSync;
            draw_q       <= 1'b0;
            pixelX_q     <= '0;
            pixelY_q     <= '0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            hBp_q        <= hBp_d;
            hAct_q       <= hAct_d;
            hFp_q        <= hFp_d;
            hSl_q        <= hSl_d;
            vBp_q        <= vBp_d;
            vAct_q       <= vAct_d;
            vFp_q        <= vFp_d;
            vSl_q        <= vSl_d;
            hPol_q       <= hPol_d;
            vPol_q       <= vPol_d;
            hSyncOut_q   <= hSyncOut_d;
            vSyncOut_q   <= vSyncOut_d;
            draw_q       <= draw_d;
            pixelX_q     <= pixelX_d;
            pixelY_q     <= pixelY_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign h_sync      = hSyncOut_q;
    assign v_sync      = vSyncOut_q;
    assign draw_flag   = draw_q;
    assign pixel_x     = pixelX_q;
    assign pixel_y     = pixelY_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;

endmodule
